// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux4_scan_ctrl
// Brief    : Round-robin select controller for a 4:1 mux tree. Holds each
//            enabled channel for dwell+1 cycles. It flags the last hold cycle
//            of a channel (chan_done) and the wrap of the scan order
//            (scan_wrap). All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [3:0]         chan_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               sel_valid,
    output logic               chan_done,
    output logic               scan_wrap
);

    localparam logic [DWELL_W-1:0] c_one = DWELL_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t             r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_ptr;
    logic [1:0]         r_nxt;
    logic               r_nxt_ok;

    // First enabled channel at or after base in circular order.
    // Bit 2 of the result is "found", bits 1:0 are the channel index.
    function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // A wrap is a found successor whose index does not advance past cur.
    function automatic logic wraps(input logic [2:0] la, input logic [1:0] cur);
        return la[2] && (la[1:0] <= cur);
    endfunction

    logic [2:0] w_start;
    logic [1:0] w_load_sel;
    logic [2:0] w_la_load;
    logic [2:0] w_la_hold;

    // Channel search for a fresh start, for the channel about to be loaded,
    // and for the successor of the channel currently held.
    always_comb begin
        w_start    = pick(chan_en, r_ptr);
        w_load_sel = (r_state == IDLE) ? w_start[1:0] : r_nxt;
        w_la_load  = pick(chan_en, w_load_sel + 2'd1);
        w_la_hold  = pick(chan_en, sel + 2'd1);
    end

    // Scan FSM. chan_done/scan_wrap are computed one edge early, at the edge
    // that makes the counter reach zero, so they are plain registers. The
    // successor found at that edge is kept in r_nxt for the following load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= 2'd0;
            r_nxt     <= 2'd0;
            r_nxt_ok  <= 1'b0;
            sel       <= 2'd0;
            sel_valid <= 1'b0;
            chan_done <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    chan_done <= 1'b0;
                    scan_wrap <= 1'b0;
                    if (en && w_start[2]) begin
                        sel       <= w_start[1:0];
                        sel_valid <= 1'b1;
                        r_cnt     <= dwell;
                        r_state   <= DWELL;
                        if (dwell == '0) begin
                            chan_done <= 1'b1;
                            r_nxt     <= w_la_load[1:0];
                            r_nxt_ok  <= w_la_load[2];
                            scan_wrap <= wraps(w_la_load, w_start[1:0]);
                        end
                    end
                end
                DWELL: begin
                    if (!en) begin
                        // Abort: no completion flag; resume restarts this channel.
                        sel_valid <= 1'b0;
                        chan_done <= 1'b0;
                        scan_wrap <= 1'b0;
                        r_ptr     <= sel;
                        r_state   <= IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_one;
                        if (r_cnt == c_one) begin
                            chan_done <= 1'b1;
                            r_nxt     <= w_la_hold[1:0];
                            r_nxt_ok  <= w_la_hold[2];
                            scan_wrap <= wraps(w_la_hold, sel);
                        end else begin
                            chan_done <= 1'b0;
                            scan_wrap <= 1'b0;
                        end
                    end else if (r_nxt_ok) begin
                        sel   <= r_nxt;
                        r_cnt <= dwell;
                        if (dwell == '0) begin
                            chan_done <= 1'b1;
                            r_nxt     <= w_la_load[1:0];
                            r_nxt_ok  <= w_la_load[2];
                            scan_wrap <= wraps(w_la_load, r_nxt);
                        end else begin
                            chan_done <= 1'b0;
                            scan_wrap <= 1'b0;
                        end
                    end else begin
                        // Mask drained: park and resume after this channel.
                        sel_valid <= 1'b0;
                        chan_done <= 1'b0;
                        scan_wrap <= 1'b0;
                        r_ptr     <= sel + 2'd1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_scan_ctrl
// Brief    : Self-checking bench for mux4_scan_ctrl: a vector table for the
//            steady scan patterns, hand sequences for reset, abort/resume
//            and mask drain. Expected outputs go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] chan_en;
    logic [7:0] dwell;
    logic [1:0] sel;
    logic       sel_valid;
    logic       chan_done;
    logic       scan_wrap;

    mux4_scan_ctrl #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .chan_en   (chan_en),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .chan_done (chan_done),
        .scan_wrap (scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       valid;
        logic       done;
        logic       wrap;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] mask;
        logic [7:0] dwell;
        logic [1:0] sel;
        logic       valid;
        logic       done;
        logic       wrap;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got sel/valid/done/wrap=%b required %b at %0t", name, act, req, $time);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no clock edge.
    task automatic do_reset(input string name);
        en      = 1'b0;
        rst_n   = 1'b0;
        #2;
        check(name, {sel, sel_valid, chan_done, scan_wrap}, 5'b00000);
        rst_n = 1'b1;
    endtask

    // Drive inputs, queue the expectation, then compare just after the edge.
    task automatic step(input string name, input logic e, input logic [3:0] m, input logic [7:0] d,
                        input logic [1:0] s, input logic v, input logic dn, input logic w);
        exp_t x;
        en      = e;
        chan_en = m;
        dwell   = d;
        sb_q.push_back('{sel: s, valid: v, done: dn, wrap: w});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb_q.pop_front();
            check(name, {sel, sel_valid, chan_done, scan_wrap}, {x.sel, x.valid, x.done, x.wrap});
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        chan_en = 4'b0000;
        dwell   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {sel, sel_valid, chan_done, scan_wrap}, 5'b00000);
        rst_n = 1'b1;

        // Idle with en low: nothing starts.
        step("idle_en_low", 1'b0, 4'b1111, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Full scan, dwell=0: one cycle per channel, wrap on sel=3.
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 8'd0, 2'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd3, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 8'd0, 2'd3, 1'b1, 1'b1, 1'b1});
        // Sparse mask 0101, dwell=2.
        tbl.push_back('{1'b1, 1'b1, 4'b0101, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd2, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd2, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd2, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b0101, 8'd2, 2'd0, 1'b1, 1'b1, 1'b0});
        // Single channel 1000, dwell=1: done+wrap every second cycle.
        tbl.push_back('{1'b1, 1'b1, 4'b1000, 8'd1, 2'd3, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 8'd1, 2'd3, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 8'd1, 2'd3, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 8'd1, 2'd3, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 8'd1, 2'd3, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 8'd1, 2'd3, 1'b1, 1'b1, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset($sformatf("tbl_reset_%0d", i));
            step($sformatf("tbl_%0d", i), tbl[i].en, tbl[i].mask, tbl[i].dwell,
                 tbl[i].sel, tbl[i].valid, tbl[i].done, tbl[i].wrap);
        end

        // Async reset mid-hold of sel=2, then restart from channel 0.
        do_reset("pre_rst_mid");
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) begin
                step($sformatf("rst_mid_run_c%0d_k%0d", c, k), 1'b1, 4'b1111, 8'd3,
                     2'(c), 1'b1, (k == 3), 1'b0);
                if (c == 2 && k == 1) break;
            end
        end
        do_reset("rst_mid_async");
        step("rst_mid_restart", 1'b1, 4'b1111, 8'd0, 2'd0, 1'b1, 1'b1, 1'b0);

        // Abort in 2nd cycle of sel=2, resume with a fresh 4-cycle hold.
        do_reset("pre_abort");
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                step("abort_run", 1'b1, 4'b1111, 8'd3, 2'(c), 1'b1, (k == 3), 1'b0);
            end
        end
        step("abort_s2_c1", 1'b1, 4'b1111, 8'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        step("abort_s2_c2", 1'b1, 4'b1111, 8'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        step("abort_drop",  1'b0, 4'b1111, 8'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        step("resume_c1",   1'b1, 4'b1111, 8'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        step("resume_c2",   1'b1, 4'b1111, 8'd7, 2'd2, 1'b1, 1'b0, 1'b0);
        step("resume_c3",   1'b1, 4'b1111, 8'd7, 2'd2, 1'b1, 1'b0, 1'b0);
        step("resume_c4",   1'b1, 4'b1111, 8'd3, 2'd2, 1'b1, 1'b1, 1'b0);
        step("resume_s3_1", 1'b1, 4'b1111, 8'd3, 2'd3, 1'b1, 1'b0, 1'b0);
        step("resume_s3_2", 1'b1, 4'b1111, 8'd3, 2'd3, 1'b1, 1'b0, 1'b0);
        step("resume_s3_3", 1'b1, 4'b1111, 8'd3, 2'd3, 1'b1, 1'b0, 1'b0);
        step("resume_s3_4", 1'b1, 4'b1111, 8'd3, 2'd3, 1'b1, 1'b1, 1'b1);

        // Mask drain: clear the mask during sel=1, then restore.
        do_reset("pre_drain");
        step("drain_s0_1",  1'b1, 4'b0011, 8'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        step("drain_s0_2",  1'b1, 4'b0011, 8'd1, 2'd0, 1'b1, 1'b1, 1'b0);
        step("drain_s1_1",  1'b1, 4'b0011, 8'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        step("drain_s1_2",  1'b1, 4'b0000, 8'd1, 2'd1, 1'b1, 1'b1, 1'b0);
        step("drain_idle1", 1'b1, 4'b0000, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        step("drain_idle2", 1'b1, 4'b0000, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        step("drain_res_1", 1'b1, 4'b0011, 8'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        step("drain_res_2", 1'b1, 4'b0011, 8'd1, 2'd0, 1'b1, 1'b1, 1'b0);
        step("drain_res_3", 1'b1, 4'b0011, 8'd1, 2'd1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
